param_datapath: RTL and testbench

//  Parametrised single-bus CPU datapath: GPR file plus HI, LO, PC, IR, Y, Z(2*DATA_W), MAR and MDR.

---
 rtl/dp_pkg.sv | 39 +++
 rtl/param_datapath_if.sv | 23 ++
 rtl/seq_multiplier.sv | 69 ++++++
 rtl/param_datapath.sv | 197 +++++++++++++++++++
 tb/tb_param_datapath.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dp_pkg.sv
// Shared constants for the parametrised single-bus datapath: ALU opcodes,
// destination/source index offsets (added to NUM_GPR) and the memory FSM states.
package dp_pkg;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SHL = 3'd4;
    localparam logic [2:0] ALU_SHR = 3'd5;
    localparam logic [2:0] ALU_NOT = 3'd6;
    localparam logic [2:0] ALU_MUL = 3'd7;

    // Destination enables sit above the GPR block: dst_en[NUM_GPR + DST_x]
    localparam int DST_HI  = 0;
    localparam int DST_LO  = 1;
    localparam int DST_PC  = 2;
    localparam int DST_IR  = 3;
    localparam int DST_Y   = 4;
    localparam int DST_Z   = 5;
    localparam int DST_MAR = 6;
    localparam int DST_MDR = 7;
    localparam int NUM_DST_EXTRA = 8;

    // Bus sources likewise: src_sel[NUM_GPR + SRC_x]
    localparam int SRC_HI  = 0;
    localparam int SRC_LO  = 1;
    localparam int SRC_ZHI = 2;
    localparam int SRC_ZLO = 3;
    localparam int SRC_PC  = 4;
    localparam int SRC_MDR = 5;
    localparam int NUM_SRC_EXTRA = 6;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_REQ  = 1'b1
    } mem_state_e;

endpackage

// File: rtl/param_datapath_if.sv
// Memory-read handshake between the datapath (master) and the memory interface (slave).
interface param_datapath_if #(
    parameter int DATA_W = 32
);
    logic              mem_req;
    logic [DATA_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;

    modport master (
        output mem_req,
        output mem_addr,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_addr,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/seq_multiplier.sv
// Unsigned shift-add multiplier, one multiplier bit per cycle. done_o marks the cycle whose
// closing edge completes the product; product_o carries the full result in that cycle.
module seq_multiplier #(
    parameter int W = 32
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start_i,
    input  logic [W-1:0]   a_i,
    input  logic [W-1:0]   b_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [2*W-1:0] product_o
);
    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2*W-1:0]   acc_q, acc_d;
    logic [2*W-1:0]   mcand_q, mcand_d;
    logic [W-1:0]     mplr_q, mplr_d;
    logic [2*W-1:0]   acc_step;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        acc_step = acc_q + (mplr_q[0] ? mcand_q : '0);
        busy_d   = busy_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplr_d   = mplr_q;
        done_o   = busy_q && (cnt_q == CNT_W'(W - 1));
        if (busy_q) begin
            acc_d   = acc_step;
            mcand_d = mcand_q << 1;
            mplr_d  = mplr_q >> 1;
            cnt_d   = cnt_q + 1'b1;
            if (done_o) begin
                busy_d = 1'b0;
            end
        end else if (start_i) begin
            busy_d  = 1'b1;
            cnt_d   = '0;
            acc_d   = '0;
            mcand_d = {{W{1'b0}}, a_i};
            mplr_d  = b_i;
        end
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            acc_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
        end else begin
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
        end
    end

    assign busy_o    = busy_q;
    assign product_o = acc_step;
endmodule

// File: rtl/param_datapath.sv
// Parametrised single-bus CPU datapath: GPR file, HI/LO/PC/IR/Y/Z/MAR/MDR, one-hot bus mux
// with error detection, ALU with sequential multiplier and a req/ack memory read into MDR.
module param_datapath
    import dp_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int NUM_GPR = 16,
    parameter bit R0_ZERO = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_GPR+7:0]    dst_en,
    input  logic [NUM_GPR+5:0]    src_sel,
    input  logic [2:0]            alu_op,
    input  logic                  pc_inc,
    input  logic                  mem_rd,
    param_datapath_if.master      mem,
    output logic                  busy,
    output logic                  alu_done,
    output logic                  bus_err,
    output logic [DATA_W-1:0]     bus_data,
    output logic [DATA_W-1:0]     ir_q
);
    localparam int NUM_SRC = NUM_GPR + NUM_SRC_EXTRA;
    localparam int SH_W    = $clog2(DATA_W);

    localparam int D_HI  = NUM_GPR + DST_HI;
    localparam int D_LO  = NUM_GPR + DST_LO;
    localparam int D_PC  = NUM_GPR + DST_PC;
    localparam int D_IR  = NUM_GPR + DST_IR;
    localparam int D_Y   = NUM_GPR + DST_Y;
    localparam int D_Z   = NUM_GPR + DST_Z;
    localparam int D_MAR = NUM_GPR + DST_MAR;
    localparam int D_MDR = NUM_GPR + DST_MDR;

    logic [DATA_W-1:0]   gpr_q [NUM_GPR];
    logic [DATA_W-1:0]   gpr_d [NUM_GPR];
    logic [DATA_W-1:0]   hi_q, hi_d, lo_q, lo_d, pc_q, pc_d, ir_d;
    logic [DATA_W-1:0]   y_q, y_d, mar_q, mar_d, mdr_q, mdr_d;
    logic [2*DATA_W-1:0] z_q, z_d;
    mem_state_e          mem_state_q, mem_state_d;
    logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
    logic                alu_done_q;

    logic                mul_start, mul_busy, mul_done;
    logic [2*DATA_W-1:0] mul_product;
    logic [DATA_W-1:0]   src_val [NUM_SRC];
    logic [DATA_W-1:0]   alu_res;
    logic [SH_W-1:0]     shamt;

    always_comb begin
        for (int i = 0; i < NUM_GPR; i++) begin
            src_val[i] = gpr_q[i];
        end
        if (R0_ZERO) begin
            src_val[0] = '0;
        end
        src_val[NUM_GPR + SRC_HI]  = hi_q;
        src_val[NUM_GPR + SRC_LO]  = lo_q;
        src_val[NUM_GPR + SRC_ZHI] = z_q[2*DATA_W-1:DATA_W];
        src_val[NUM_GPR + SRC_ZLO] = z_q[DATA_W-1:0];
        src_val[NUM_GPR + SRC_PC]  = pc_q;
        src_val[NUM_GPR + SRC_MDR] = mdr_q;
    end

    // Illegal multi-source selects force the bus to zero rather than OR-ing sources
    assign bus_err = ($countones(src_sel) > 1);

    always_comb begin
        bus_data = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_sel[i]) begin
                bus_data = bus_data | src_val[i];
            end
        end
        if (bus_err) begin
            bus_data = '0;
        end
    end

    assign shamt = bus_data[SH_W-1:0];

    always_comb begin
        alu_res = '0;
        case (alu_op)
            ALU_ADD: alu_res = y_q + bus_data;
            ALU_SUB: alu_res = y_q - bus_data;
            ALU_AND: alu_res = y_q & bus_data;
            ALU_OR:  alu_res = y_q | bus_data;
            ALU_SHL: alu_res = y_q << shamt;
            ALU_SHR: alu_res = y_q >> shamt;
            ALU_NOT: alu_res = ~y_q;
            default: alu_res = '0;
        endcase
    end

    assign mul_start = dst_en[D_Z] && !mul_busy && (alu_op == ALU_MUL);

    seq_multiplier #(.W(DATA_W)) u_mul (
        .clk       (clk),
        .reset     (reset),
        .start_i   (mul_start),
        .a_i       (y_q),
        .b_i       (bus_data),
        .busy_o    (mul_busy),
        .done_o    (mul_done),
        .product_o (mul_product)
    );

    always_comb begin
        gpr_d = gpr_q;
        for (int i = 0; i < NUM_GPR; i++) begin
            if (dst_en[i]) begin
                gpr_d[i] = bus_data;
            end
        end
        if (R0_ZERO) begin
            gpr_d[0] = '0;
        end
        hi_d  = dst_en[D_HI]  ? bus_data : hi_q;
        lo_d  = dst_en[D_LO]  ? bus_data : lo_q;
        ir_d  = dst_en[D_IR]  ? bus_data : ir_q;
        y_d   = dst_en[D_Y]   ? bus_data : y_q;
        mar_d = dst_en[D_MAR] ? bus_data : mar_q;
        mdr_d = dst_en[D_MDR] ? bus_data : mdr_q;

        pc_d = pc_q;
        if (dst_en[D_PC]) begin
            pc_d = bus_data;
        end else if (pc_inc) begin
            pc_d = pc_q + 1'b1;
        end

        // Z is owned by the multiplier from accept until its result lands
        z_d = z_q;
        if (mul_done) begin
            z_d = mul_product;
        end else if (dst_en[D_Z] && !mul_busy && (alu_op != ALU_MUL)) begin
            z_d = {{DATA_W{1'b0}}, alu_res};
        end

        mem_state_d = mem_state_q;
        mem_addr_d  = mem_addr_q;
        case (mem_state_q)
            MEM_IDLE: begin
                if (mem_rd) begin
                    mem_state_d = MEM_REQ;
                    mem_addr_d  = mar_q;
                end
            end
            MEM_REQ: begin
                if (mem.mem_ack) begin
                    mem_state_d = MEM_IDLE;
                    mdr_d       = mem.mem_rdata;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the register file is built from flops, so it clears with everything else.
            for (int i = 0; i < NUM_GPR; i++) begin
                gpr_q[i] <= '0;
            end
            hi_q        <= '0;
            lo_q        <= '0;
            pc_q        <= '0;
            ir_q        <= '0;
            y_q         <= '0;
            z_q         <= '0;
            mar_q       <= '0;
            mdr_q       <= '0;
            mem_state_q <= MEM_IDLE;
            mem_addr_q  <= '0;
            alu_done_q  <= 1'b0;
        end else begin
            gpr_q       <= gpr_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            y_q         <= y_d;
            z_q         <= z_d;
            mar_q       <= mar_d;
            mdr_q       <= mdr_d;
            mem_state_q <= mem_state_d;
            mem_addr_q  <= mem_addr_d;
            alu_done_q  <= mul_done;
        end
    end

    assign busy         = mul_busy || (mem_state_q == MEM_REQ);
    assign alu_done     = alu_done_q;
    assign mem.mem_req  = (mem_state_q == MEM_REQ);
    assign mem.mem_addr = mem_addr_q;
endmodule

// File: tb/tb_param_datapath.sv
// Self-checking bench for param_datapath (32-bit, 16 GPRs, R0 hard-wired to zero):
// directed scenarios followed by random traffic against a behavioural model.
module tb_param_datapath;
    import dp_pkg::*;

    localparam int W  = 32;
    localparam int NG = 16;
    localparam int ND = NG + NUM_DST_EXTRA;
    localparam int NS = NG + NUM_SRC_EXTRA;

    localparam int D_HI  = NG + DST_HI;
    localparam int D_LO  = NG + DST_LO;
    localparam int D_PC  = NG + DST_PC;
    localparam int D_IR  = NG + DST_IR;
    localparam int D_Y   = NG + DST_Y;
    localparam int D_Z   = NG + DST_Z;
    localparam int D_MAR = NG + DST_MAR;
    localparam int D_MDR = NG + DST_MDR;
    localparam int S_ZHI = NG + SRC_ZHI;
    localparam int S_ZLO = NG + SRC_ZLO;
    localparam int S_PC  = NG + SRC_PC;
    localparam int S_MDR = NG + SRC_MDR;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [ND-1:0] dst_en;
    logic [NS-1:0] src_sel;
    logic [2:0]    alu_op;
    logic          pc_inc, mem_rd, mem_ack;
    logic [W-1:0]  mem_rdata;
    logic          busy, alu_done, bus_err;
    logic [W-1:0]  bus_data, ir_q;

    param_datapath_if #(.DATA_W(W)) mem_if ();
    assign mem_if.mem_ack   = mem_ack;
    assign mem_if.mem_rdata = mem_rdata;

    param_datapath #(.DATA_W(W), .NUM_GPR(NG), .R0_ZERO(1'b1)) dut (
        .clk      (clk),
        .reset    (reset),
        .dst_en   (dst_en),
        .src_sel  (src_sel),
        .alu_op   (alu_op),
        .pc_inc   (pc_inc),
        .mem_rd   (mem_rd),
        .mem      (mem_if.master),
        .busy     (busy),
        .alu_done (alu_done),
        .bus_err  (bus_err),
        .bus_data (bus_data),
        .ir_q     (ir_q)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Architectural model state
    logic [W-1:0]   m_gpr [NG];
    logic [W-1:0]   m_hi, m_lo, m_pc, m_ir, m_y, m_mar, m_mdr, m_addr;
    logic [2*W-1:0] m_z, m_prod;
    int             m_mul_left;
    bit             m_pend, m_done;
    logic [W-1:0]   bus_seen;
    logic           err_seen;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [NS-1:0] sel(input int i);
        logic [NS-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [W-1:0] m_src(input int i);
        if (i < NG) return (i == 0) ? '0 : m_gpr[i];
        case (i - NG)
            SRC_HI:  return m_hi;
            SRC_LO:  return m_lo;
            SRC_ZHI: return m_z[2*W-1:W];
            SRC_ZLO: return m_z[W-1:0];
            SRC_PC:  return m_pc;
            default: return m_mdr;
        endcase
    endfunction

    function automatic logic [W-1:0] m_bus();
        int cnt = 0;
        int idx = 0;
        for (int i = 0; i < NS; i++) begin
            if (src_sel[i]) begin
                cnt++;
                idx = i;
            end
        end
        return (cnt == 1) ? m_src(idx) : '0;
    endfunction

    function automatic logic [W-1:0] m_alu(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        case (op)
            3'd0:    return a + b;
            3'd1:    return a - b;
            3'd2:    return a & b;
            3'd3:    return a | b;
            3'd4:    return a << b[4:0];
            3'd5:    return a >> b[4:0];
            default: return ~a;
        endcase
    endfunction

    task automatic m_reset();
        for (int i = 0; i < NG; i++) m_gpr[i] = '0;
        m_hi = '0; m_lo = '0; m_pc = '0; m_ir = '0; m_y = '0;
        m_mar = '0; m_mdr = '0; m_addr = '0; m_z = '0; m_prod = '0;
        m_mul_left = 0; m_pend = 0; m_done = 0;
    endtask

    // Advance the model by one rising edge using the inputs currently applied
    task automatic m_edge();
        logic [W-1:0] b, old_y, old_mar;
        b       = m_bus();
        old_y   = m_y;
        old_mar = m_mar;
        for (int i = 1; i < NG; i++) if (dst_en[i]) m_gpr[i] = b;
        if (dst_en[D_HI])  m_hi  = b;
        if (dst_en[D_LO])  m_lo  = b;
        if (dst_en[D_IR])  m_ir  = b;
        if (dst_en[D_Y])   m_y   = b;
        if (dst_en[D_MAR]) m_mar = b;
        if (dst_en[D_PC])  m_pc  = b;
        else if (pc_inc)   m_pc  = m_pc + 32'd1;
        m_done = 0;
        if (m_mul_left > 0) begin
            m_mul_left--;
            if (m_mul_left == 0) begin
                m_z    = m_prod;
                m_done = 1;
            end
        end else if (dst_en[D_Z]) begin
            if (alu_op == 3'd7) begin
                m_mul_left = W;
                m_prod     = {32'h0, old_y} * {32'h0, b};
            end else begin
                m_z = {32'h0, m_alu(alu_op, old_y, b)};
            end
        end
        if (dst_en[D_MDR]) m_mdr = b;
        if (m_pend) begin
            if (mem_ack) begin
                m_mdr  = mem_rdata;
                m_pend = 0;
            end
        end else if (mem_rd) begin
            m_pend = 1;
            m_addr = old_mar;
        end
    endtask

    task automatic idle();
        dst_en = '0; src_sel = '0; alu_op = 3'd0; pc_inc = 1'b0;
        mem_rd = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    endtask

    // Entered 1 time unit after a rising edge; checks the bus mid-cycle, clocks once, checks state
    task automatic step();
        logic [W-1:0] eb;
        #3;
        eb       = m_bus();
        bus_seen = bus_data;
        err_seen = bus_err;
        check("bus_data", 64'(bus_data), 64'(eb));
        check("bus_err", 64'(bus_err), 64'(($countones(src_sel) > 1) ? 1 : 0));
        m_edge();
        @(posedge clk);
        #1;
        check("busy", 64'(busy), 64'((m_mul_left > 0 || m_pend) ? 1 : 0));
        check("alu_done", 64'(alu_done), 64'(m_done));
        check("mem_req", 64'(mem_if.mem_req), 64'(m_pend));
        check("mem_addr", 64'(mem_if.mem_addr), 64'(m_addr));
        check("ir_q", 64'(ir_q), 64'(m_ir));
    endtask

    task automatic expect_src(input string tag, input int idx, input logic [W-1:0] v);
        idle();
        src_sel = sel(idx);
        step();
        check(tag, 64'(bus_seen), 64'(v));
        idle();
    endtask

    // External data enters only through MDR: read it from memory, then move it
    task automatic load_reg(input int dst, input logic [W-1:0] v);
        idle();
        mem_rd = 1'b1;
        step();
        idle();
        mem_ack   = 1'b1;
        mem_rdata = v;
        step();
        idle();
        dst_en[dst] = 1'b1;
        src_sel     = sel(S_MDR);
        step();
        idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int done_cnt, done_at, req_cycles, r;
        idle();
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        check("rst_busy", 64'(busy), 64'(0));
        check("rst_alu_done", 64'(alu_done), 64'(0));
        check("rst_mem_req", 64'(mem_if.mem_req), 64'(0));
        check("rst_ir", 64'(ir_q), 64'(0));

        // Reset mid-operation with a multiply and a memory read in flight
        load_reg(3, 32'h1234);
        expect_src("r3_loaded", 3, 32'h1234);
        load_reg(D_Y, 32'h7);
        mem_rd = 1'b1; dst_en[D_Z] = 1'b1; alu_op = 3'd7; src_sel = sel(3);
        step();
        idle();
        step();
        check("inflight_busy", 64'(busy), 64'(1));
        src_sel = sel(3);
        #2 reset = 1'b1;
        #1;
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_alu_done", 64'(alu_done), 64'(0));
        check("midrst_mem_req", 64'(mem_if.mem_req), 64'(0));
        check("midrst_bus", 64'(bus_data), 64'(0));
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_reset();
        idle();
        expect_src("r3_cleared", 3, 32'h0);
        expect_src("z_not_written", S_ZLO, 32'h0);

        // Bus source errors
        load_reg(1, 32'h1);
        load_reg(2, 32'hFFFF_FFFF);
        src_sel = sel(1) | sel(2);
        step();
        check("multi_bus_err", 64'(err_seen), 64'(1));
        check("multi_bus_zero", 64'(bus_seen), 64'(0));
        expect_src("single_src", 1, 32'h1);
        check("single_bus_err", 64'(err_seen), 64'(0));

        // Single-cycle ALU wrap-around
        load_reg(D_Y, 32'hFFFF_FFFF);
        dst_en[D_Z] = 1'b1; alu_op = 3'd3; src_sel = sel(1);
        step();
        idle();
        expect_src("or_zlo", S_ZLO, 32'hFFFF_FFFF);
        dst_en[D_Z] = 1'b1; alu_op = 3'd0; src_sel = sel(1);
        step();
        idle();
        expect_src("add_zhi", S_ZHI, 32'h0);
        expect_src("add_zlo", S_ZLO, 32'h0);
        dst_en[D_Z] = 1'b1; alu_op = 3'd2; src_sel = sel(2);
        step();
        dst_en[D_Z] = 1'b1; alu_op = 3'd1; src_sel = sel(2);
        step();
        idle();
        expect_src("sub_zlo", S_ZLO, 32'h0);

        // Multiplier: latency, single done pulse, second MUL and Y change ignored
        dst_en[D_Z] = 1'b1; alu_op = 3'd7; src_sel = sel(2);
        step();
        check("mul_busy", 64'(busy), 64'(1));
        dst_en[D_Z] = 1'b1; dst_en[D_Y] = 1'b1; alu_op = 3'd7; src_sel = sel(1);
        step();
        idle();
        done_cnt = 0;
        done_at  = -1;
        for (int c = 2; c <= 40; c++) begin
            step();
            if (alu_done) begin
                done_cnt++;
                if (done_at < 0) done_at = c;
            end
        end
        check("mul_latency", 64'(done_at), 64'(32));
        check("mul_done_pulses", 64'(done_cnt), 64'(1));
        expect_src("mul_zhi", S_ZHI, 32'hFFFF_FFFE);
        expect_src("mul_zlo", S_ZLO, 32'h0000_0001);

        // Memory read with three wait states; same-cycle MDR load loses to memory data
        load_reg(D_MAR, 32'h40);
        mem_rd = 1'b1;
        step();
        idle();
        req_cycles = int'(mem_if.mem_req);
        check("rd_addr", 64'(mem_if.mem_addr), 64'(32'h40));
        for (int i = 0; i < 3; i++) begin
            mem_rd = (i == 0);
            step();
            req_cycles += int'(mem_if.mem_req);
        end
        idle();
        mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D; dst_en[D_MDR] = 1'b1; src_sel = sel(1);
        step();
        req_cycles += int'(mem_if.mem_req);
        idle();
        check("req_cycles", 64'(req_cycles), 64'(4));
        expect_src("mdr_mem_wins", S_MDR, 32'hCAFE_F00D);
        mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        step();
        idle();
        expect_src("idle_ack_ignored", S_MDR, 32'hCAFE_F00D);

        // PC wrap, load priority over increment, R0 hard-wired
        load_reg(D_PC, 32'hFFFF_FFFF);
        pc_inc = 1'b1;
        step();
        idle();
        expect_src("pc_wrap", S_PC, 32'h0);
        load_reg(4, 32'h10);
        pc_inc = 1'b1; dst_en[D_PC] = 1'b1; src_sel = sel(4);
        step();
        idle();
        expect_src("pc_load_prio", S_PC, 32'h10);
        load_reg(5, 32'h5);
        dst_en[0] = 1'b1; src_sel = sel(5);
        step();
        idle();
        expect_src("r0_zero", 0, 32'h0);

        // Random traffic against the model
        for (int n = 0; n < 1500; n++) begin
            for (int i = 0; i < ND; i++) dst_en[i] = ($urandom_range(0, 7) == 0);
            r = int'($urandom_range(0, 9));
            if (r == 0)      src_sel = '0;
            else if (r == 1) src_sel = sel(int'($urandom_range(0, NS-1))) | sel(int'($urandom_range(0, NS-1)));
            else             src_sel = sel(int'($urandom_range(0, NS-1)));
            alu_op    = 3'($urandom_range(0, 7));
            pc_inc    = ($urandom_range(0, 3) == 0);
            mem_rd    = ($urandom_range(0, 3) == 0);
            mem_ack   = ($urandom_range(0, 2) == 0);
            mem_rdata = $urandom;
            step();
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
